image_scanout_ctrl: RTL

Frame scan-out sequencer for the image memory. On a start pulse it walks the read port of the distributed image memory linearly over one full frame and streams the pixels to the LCD pixel interface. The stream uses valid/ready backpressure and carries start-of-frame and end-of-line markers. A small credit-controlled FIFO absorbs the memory's fixed read latency, so the read port can be throttled without losing data in flight.

---
 rtl/image_scanout_ctrl_if.sv | 37 +++
 rtl/image_scanout_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_scanout_ctrl_if.sv
`timescale 1ns/1ps
// image_scanout_ctrl_if
// Bundles the two bus-like port groups of the frame scan-out sequencer:
//   - image memory read port : rd_en_o, rd_clk_en_o, rd_addr_o (controller -> memory),
//                              rd_data_i (memory -> controller)
//   - LCD pixel stream       : pix_data_o, pix_valid_o, pix_sof_o, pix_eol_o
//                              (controller -> sink), pix_ready_i (sink -> controller)
// The _i/_o suffixes are from the controller's point of view.
// Modports: master = the controller, slave = the memory/sink environment.
interface image_scanout_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic                  rd_en_o;
  logic                  rd_clk_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic [DATA_WIDTH-1:0] pix_data_o;
  logic                  pix_valid_o;
  logic                  pix_ready_i;
  logic                  pix_sof_o;
  logic                  pix_eol_o;

  modport master (
    output rd_en_o, rd_clk_en_o, rd_addr_o,
    input  rd_data_i,
    output pix_data_o, pix_valid_o, pix_sof_o, pix_eol_o,
    input  pix_ready_i
  );

  modport slave (
    input  rd_en_o, rd_clk_en_o, rd_addr_o,
    output rd_data_i,
    input  pix_data_o, pix_valid_o, pix_sof_o, pix_eol_o,
    output pix_ready_i
  );
endinterface

// File: rtl/image_scanout_ctrl.sv
`timescale 1ns/1ps
// image_scanout_ctrl
// Frame scan-out sequencer. On start_i it reads the image memory linearly over
// one H_PIXELS x V_LINES frame and streams the pixels out with valid/ready
// backpressure, tagging the first pixel of the frame (sof) and the last pixel
// of every line (eol). A credit-limited show-ahead FIFO absorbs the fixed
// memory read latency so reads can be throttled without losing data.
// Ports:
//   clk_i        single clock (memory read clock is the same)
//   rst_n_i      asynchronous active-low reset
//   start_i      one-cycle frame request, only honoured when idle
//   abort_i      one-cycle abort, discards everything in flight
//   busy_o       high from accepted start until done/abort
//   frame_done_o one-cycle pulse after the last pixel is accepted
//   bus          memory read port + pixel stream (image_scanout_ctrl_if.master)
module image_scanout_ctrl #(
  parameter int H_PIXELS   = 128,
  parameter int V_LINES    = 128,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(H_PIXELS * V_LINES),
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic frame_done_o,
  image_scanout_ctrl_if.master bus
);

  localparam int NPIX = H_PIXELS * V_LINES;
  localparam int XW   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int FW   = DATA_WIDTH + 2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(H_PIXELS - 1);
  localparam logic [PW-1:0]         LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [RD_LATENCY-1:0]   pvld_q, pvld_d;
  logic [RD_LATENCY-1:0]   psof_q, psof_d;
  logic [RD_LATENCY-1:0]   peol_q, peol_d;
  logic [FW-1:0]           fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic [CW-1:0]           in_flight_s;
  logic [CW:0]             credit_sum_s;
  logic                    rd_en_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    last_issue_s;
  logic                    frame_end_s;
  logic                    valid_s;
  logic [FW-1:0]           head_s;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Reads issued but not yet written into the FIFO = live stages of the tag pipe.
  always_comb begin
    in_flight_s = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight_s = in_flight_s + CW'(pvld_q[i]);
    end
  end

  // Credit rule: a read may only go out if its data is guaranteed a FIFO slot.
  assign credit_sum_s = {1'b0, in_flight_s} + {1'b0, count_q};
  assign rd_en_s      = (state_q == FETCH) && (credit_sum_s < {1'b0, DEPTH_C});
  assign last_issue_s = rd_en_s && (addr_q == LAST_ADDR);
  assign push_s       = pvld_q[RD_LATENCY-1];
  assign valid_s      = (count_q != '0);
  assign pop_s        = valid_s && bus.pix_ready_i;
  // No pushes remain once in_flight is zero in DRAIN, so the frame ends when
  // the FIFO is empty or its last entry is leaving this cycle.
  assign frame_end_s  = (state_q == DRAIN) && (in_flight_s == '0) &&
                        ((count_q == '0) || ((count_q == CW'(1)) && pop_s));

  // Sequencer next state: address/x/y walk and frame completion.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = FETCH;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          if (last_issue_s) begin
            // Address parks on the final pixel so it never leaves the frame.
            state_d = DRAIN;
          end else if (rd_en_s) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (x_q == LAST_X) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end else begin
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (frame_end_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Return tag pipe: follows each read for RD_LATENCY cycles with its markers.
  always_comb begin
    pvld_d    = pvld_q;
    psof_d    = psof_q;
    peol_d    = peol_q;
    pvld_d[0] = rd_en_s;
    psof_d[0] = (x_q == '0) && (y_q == '0);
    peol_d[0] = (x_q == LAST_X);
    for (int i = 1; i < RD_LATENCY; i++) begin
      pvld_d[i] = pvld_q[i-1];
      psof_d[i] = psof_q[i-1];
      peol_d[i] = peol_q[i-1];
    end
    if (abort_i) begin
      pvld_d = '0;
    end else begin
      pvld_d = pvld_d;
    end
  end

  // FIFO pointer and occupancy bookkeeping; abort empties it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, counters, tag pipe and FIFO control registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pvld_q   <= '0;
      psof_q   <= '0;
      peol_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pvld_q   <= pvld_d;
      psof_q   <= psof_d;
      peol_q   <= peol_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; entries are only observed after being written.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {psof_q[RD_LATENCY-1], peol_q[RD_LATENCY-1], bus.rd_data_i};
    end
  end

  assign head_s = fifo_mem_q[rd_ptr_q];

  assign busy_o          = busy_q;
  assign frame_done_o    = done_q;
  assign bus.rd_en_o     = rd_en_s;
  assign bus.rd_clk_en_o = rd_en_s;
  assign bus.rd_addr_o   = addr_q;
  assign bus.pix_valid_o = valid_s;
  // Head fields are forced to zero while the FIFO is empty.
  assign bus.pix_data_o  = valid_s ? head_s[DATA_WIDTH-1:0] : '0;
  assign bus.pix_eol_o   = valid_s && head_s[DATA_WIDTH];
  assign bus.pix_sof_o   = valid_s && head_s[DATA_WIDTH+1];

endmodule
